// File: rtl/div_seq_pkg.sv
// Shared types, widths and helpers for the sequential integer divider.
package div_seq_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);
  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    DIV_ST_IDLE,
    DIV_ST_PREP,
    DIV_ST_ITER,
    DIV_ST_FIX,
    DIV_ST_DONE
  } div_state_e;

  // Two's-complement negate when en is set.
  function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response handshake bundle between issue logic and the divider.
interface div_seq_if #(parameter int unsigned TAG_W = 6);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             is_unsigned;
  logic             use_mod;
  logic [31:0]      src1;
  logic [31:0]      src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  flush, in_valid, is_unsigned, use_mod, src1, src2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );

  modport master (
    output flush, in_valid, is_unsigned, use_mod, src1, src2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_seq_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dvd_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem_next_c,
  output logic            o_q_bit_c
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;

  // Remainder stays below the divisor, so the 33-bit trial sign is exact.
  assign w_shift      = {i_rem, i_dvd_msb};
  assign w_trial      = w_shift - {1'b0, i_divisor};
  assign o_q_bit_c    = ~w_trial[XLEN];
  assign o_rem_next_c = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned DIV/MOD with valid/ready handshake, tag passthrough and flush.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned TAG_W = 6
) (
  input  logic      clk,
  input  logic      resetn,
  div_seq_if.slave  bus
);

  div_state_e       r_state, w_next;
  logic [XLEN-1:0]  r_dvd, r_rem, r_dsr, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_uns, r_mod, r_sign_q, r_sign_r, r_out_valid, r_busy;
  logic [TAG_W-1:0] r_tag;
  logic             w_accept, w_take, w_zero;
  logic [XLEN-1:0]  w_rem_next;
  logic             w_q_bit;

  assign w_accept = (r_state == DIV_ST_IDLE) & bus.in_valid & ~bus.flush;
  assign w_take   = r_out_valid & bus.out_ready;
  assign w_zero   = (r_dsr == '0);

  div_step u_step (
    .i_rem        (r_rem),
    .i_dvd_msb    (r_dvd[XLEN-1]),
    .i_divisor    (r_dsr),
    .o_rem_next_c (w_rem_next),
    .o_q_bit_c    (w_q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= DIV_ST_IDLE;
    else         r_state <= w_next;
  end

  // Next state; flush wins over every other event.
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = DIV_ST_IDLE;
    end else begin
      case (r_state)
        DIV_ST_IDLE: if (w_accept) w_next = DIV_ST_PREP;
        DIV_ST_PREP: w_next = w_zero ? DIV_ST_DONE : DIV_ST_ITER;
        DIV_ST_ITER: if (r_cnt == '0) w_next = DIV_ST_FIX;
        DIV_ST_FIX:  w_next = DIV_ST_DONE;
        DIV_ST_DONE: if (w_take) w_next = DIV_ST_IDLE;
        default:     w_next = DIV_ST_IDLE;
      endcase
    end
  end

  // Datapath: r_dvd holds the raw dividend, then |dividend|, then shifts into the quotient.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dvd <= '0; r_rem <= '0; r_dsr <= '0; r_result <= '0;
      r_cnt <= '0; r_uns <= 1'b0; r_mod <= 1'b0; r_sign_q <= 1'b0; r_sign_r <= 1'b0;
      r_out_valid <= 1'b0; r_busy <= 1'b0; r_tag <= '0;
    end else begin
      r_out_valid <= (r_state == DIV_ST_DONE) && (w_next == DIV_ST_DONE);
      r_busy      <= (w_next != DIV_ST_IDLE);
      if (!bus.flush) begin
        case (r_state)
          DIV_ST_IDLE: if (w_accept) begin
            r_dvd <= bus.src1;
            r_dsr <= bus.src2;
            r_uns <= bus.is_unsigned;
            r_mod <= bus.use_mod;
            r_tag <= bus.in_tag;
          end
          DIV_ST_PREP: begin
            r_sign_q <= ~r_uns & (r_dvd[XLEN-1] ^ r_dsr[XLEN-1]);
            r_sign_r <= ~r_uns & r_dvd[XLEN-1];
            r_rem    <= '0;
            r_cnt    <= CNT_W'(DIV_ITERS - 1);
            if (w_zero) begin
              r_result <= r_mod ? r_dvd : DIV_ZERO_Q;
            end else begin
              r_dvd <= neg_if(~r_uns & r_dvd[XLEN-1], r_dvd);
              r_dsr <= neg_if(~r_uns & r_dsr[XLEN-1], r_dsr);
            end
          end
          DIV_ST_ITER: begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[XLEN-2:0], w_q_bit};
            r_cnt <= r_cnt - CNT_W'(1);
          end
          DIV_ST_FIX: r_result <= r_mod ? neg_if(r_sign_r, r_rem) : neg_if(r_sign_q, r_dvd);
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = (r_state == DIV_ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.out_tag   = r_tag;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq: results, latency, tags, backpressure, flush and reset.
module tb_div_seq;

  localparam int unsigned TAG_W = 6;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  div_seq_if #(.TAG_W(TAG_W)) bus ();

  div_seq #(.TAG_W(TAG_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             uns;
    logic             md;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    int               lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic uns, input logic md, input logic [31:0] a,
                              input logic [31:0] b, input logic [TAG_W-1:0] tag,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.uns = uns; v.md = md; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic uns, input logic md, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.in_valid    = 1'b1;
    bus.is_unsigned = uns;
    bus.use_mod     = md;
    bus.src1        = a;
    bus.src2        = b;
    bus.in_tag      = tag;
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int n;
    @(negedge clk);
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    drive_req(v.uns, v.md, v.a, v.b, v.tag);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(n);
    check({name, " latency"}, 32'(n), 32'(v.lat));
    check({name, " result"}, bus.result, v.exp);
    check({name, " tag"}, 32'(bus.out_tag), 32'(v.tag));
    release_result();
    check({name, " drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    n_cmp = 0;
    n_err = 0;
    resetn        = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0, '0);
    bus.in_valid  = 1'b0;

    vecs.push_back(mk(1, 0, 32'd100,        32'd7,          6'd5,  32'd14,         35));
    vecs.push_back(mk(1, 1, 32'd100,        32'd7,          6'd5,  32'd2,          35));
    vecs.push_back(mk(0, 0, 32'hFFFF_FFF9,  32'd2,          6'd11, 32'hFFFF_FFFD,  35));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF9,  32'd2,          6'd12, 32'hFFFF_FFFF,  35));
    vecs.push_back(mk(0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  6'd13, 32'h8000_0000,  35));
    vecs.push_back(mk(0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  6'd14, 32'd0,          35));
    vecs.push_back(mk(1, 0, 32'h1234,       32'd0,          6'd21, 32'hFFFF_FFFF,  2));
    vecs.push_back(mk(1, 1, 32'h1234,       32'd0,          6'd22, 32'h1234,       2));
    vecs.push_back(mk(0, 0, 32'h1234,       32'd0,          6'd23, 32'hFFFF_FFFF,  2));
    vecs.push_back(mk(0, 1, 32'h1234,       32'd0,          6'd24, 32'h1234,       2));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF0,  32'd0,          6'd25, 32'hFFFF_FFF0,  2));
    vecs.push_back(mk(1, 0, 32'hFFFF_FFFF,  32'd3,          6'd31, 32'h5555_5555,  35));
    vecs.push_back(mk(0, 0, 32'd7,          32'hFFFF_FFFE,  6'd32, 32'hFFFF_FFFD,  35));
    vecs.push_back(mk(0, 1, 32'd7,          32'hFFFF_FFFE,  6'd33, 32'd1,          35));
    vecs.push_back(mk(0, 0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  6'd34, 32'd3,          35));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  6'd35, 32'hFFFF_FFFF,  35));
    vecs.push_back(mk(1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  6'd36, 32'd0,          35));
    vecs.push_back(mk(1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  6'd37, 32'h8000_0000,  35));
    vecs.push_back(mk(1, 0, 32'hFFFF_FFFF,  32'd1,          6'd63, 32'hFFFF_FFFF,  35));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst out_tag", 32'(bus.out_tag), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, new request waits for handshake
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd100, 32'd7, 6'd9);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("bp latency", 32'(n), 32'd35);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd50, 32'd5, 6'd3);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp result", bus.result, 32'd14);
      check("bp tag", 32'(bus.out_tag), 32'd9);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp idle in_ready", 32'(bus.in_ready), 32'd1);
    check("bp idle busy", 32'(bus.busy), 32'd0);
    check("bp idle out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp2 busy", 32'(bus.busy), 32'd1);
    wait_valid(n);
    check("bp2 latency", 32'(n), 32'd35);
    check("bp2 result", bus.result, 32'd10);
    check("bp2 tag", 32'(bus.out_tag), 32'd3);
    release_result();

    // Flush at ITER counter 15
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd1000, 32'd3, 6'd17);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check("fl busy before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("fl busy", 32'(bus.busy), 32'd0);
    check("fl in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("fl no out_valid", 32'(seen), 32'd0);

    // Flush together with in_valid in IDLE
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd8, 32'd0, 6'd19);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fli busy", 32'(bus.busy), 32'd0);
    check("fli in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("fli no out_valid", 32'(seen), 32'd0);

    // Reset mid-ITER, then a clean op
    @(negedge clk);
    drive_req(1'b0, 1'b0, 32'd77, 32'd5, 6'h2A);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rm out_valid", 32'(bus.out_valid), 32'd0);
    check("rm result", bus.result, 32'd0);
    check("rm out_tag", 32'(bus.out_tag), 32'd0);
    check("rm busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_vec("post-reset", mk(1, 0, 32'hFFFF_FFFF, 32'd3, 6'd7, 32'h5555_5555, 35));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
